// File: rtl/buffer_tx_grupe.sv
// buffer_tx_grupe: buffers Enigma letter indices in a small FIFO and sends
// them to a UART transmitter as ASCII, split into groups of GROUP_LEN letters
// separated by a space.
// Optional feature macro: BUFFER_TX_GRUPE_CRLF_EN. When defined, every
// GROUPS_PER_LINE-th separator becomes the two bytes CR LF.
// Handshake: tx_start pulses for one cycle to launch a byte. tx_din is held
// from that pulse until the transmitter answers with tx_done. A new tx_start
// is never issued before that tx_done, and never while tx_active is high.
module buffer_tx_grupe #(
   parameter int FIFO_DEPTH      = 16,
   parameter int GROUP_LEN       = 5,
   parameter int GROUPS_PER_LINE = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        char_valid,
   input  logic [4:0]                  char_index,
   input  logic                        tx_active,
   input  logic                        tx_done,
   output logic                        tx_start,
   output logic [7:0]                  tx_din,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic [1:0]                  dbg_state
);

   localparam int          AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0]  GRP_LAST   = 4'(GROUP_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   // Which separator byte is owed before the next letter.
   typedef enum logic [1:0] {
      SEP_NONE  = 2'd0,
      SEP_SPACE = 2'd1,
      SEP_CR    = 2'd2,
      SEP_LF    = 2'd3
   } sep_t;

   logic [4:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_tx_din;
   logic          r_is_letter;
   logic [3:0]    r_grp_cnt;
   sep_t          r_sep;

`ifdef BUFFER_TX_GRUPE_CRLF_EN
   localparam int            LW        = (GROUPS_PER_LINE > 1) ? $clog2(GROUPS_PER_LINE) : 1;
   localparam logic [LW-1:0] LINE_LAST = LW'(GROUPS_PER_LINE - 1);
   logic [LW-1:0] r_line_cnt;
`endif

   logic       w_empty;
   logic       w_full;
   logic       w_idx_ok;
   logic       w_pop;
   logic       w_push;
   logic       w_drop;
   logic [4:0] w_head;
   logic       w_load;
   logic       w_load_letter;
   logic [7:0] w_load_byte;
   logic [7:0] w_sep_byte;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == FULL_COUNT);
   assign w_idx_ok = (char_index <= 5'd25);
   assign w_head   = r_mem[r_rd_ptr];
   // A letter leaves the FIFO in the START cycle of its own byte.
   assign w_pop    = (r_state == ST_START) && r_is_letter;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push   = char_valid && w_idx_ok && (!w_full || w_pop);
   assign w_drop   = char_valid && w_idx_ok && w_full && !w_pop;

   assign tx_start   = (r_state == ST_START);
   assign tx_din     = r_tx_din;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign dbg_state  = r_state;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and byte selection. An owed separator wins over the letter,
   // and both require a letter in the FIFO, so no separator can trail the
   // final letter.
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_load_letter = 1'b0;
      w_load_byte   = 8'h00;
      case (r_sep)
         SEP_CR:  w_sep_byte = 8'h0D;
         SEP_LF:  w_sep_byte = 8'h0A;
         default: w_sep_byte = 8'h20;
      endcase
      case (r_state)
         ST_IDLE: begin
            if (!w_empty && !tx_active) begin
               w_load      = 1'b1;
               w_state_nxt = ST_START;
               if (r_sep != SEP_NONE) begin
                  w_load_byte = w_sep_byte;
               end else begin
                  w_load_letter = 1'b1;
                  w_load_byte   = {3'b000, w_head} + 8'h41;
               end
            end
         end
         ST_START:     w_state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (tx_done) w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   // Character storage. It needs no reset because the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= char_index;
   end

   // FIFO bookkeeping, output byte latch, and group/separator tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_tx_din    <= 8'h00;
         r_is_letter <= 1'b0;
         r_grp_cnt   <= '0;
         r_sep       <= SEP_NONE;
`ifdef BUFFER_TX_GRUPE_CRLF_EN
         r_line_cnt  <= '0;
`endif
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
         if (w_drop) r_overflow <= 1'b1;
         if (w_load) begin
            r_tx_din    <= w_load_byte;
            r_is_letter <= w_load_letter;
         end
         if (r_state == ST_START) begin
            if (r_is_letter) begin
               if (r_grp_cnt == GRP_LAST) begin
                  r_grp_cnt <= '0;
`ifdef BUFFER_TX_GRUPE_CRLF_EN
                  if (r_line_cnt == LINE_LAST) begin
                     r_line_cnt <= '0;
                     r_sep      <= SEP_CR;
                  end else begin
                     r_line_cnt <= r_line_cnt + LW'(1);
                     r_sep      <= SEP_SPACE;
                  end
`else
                  r_sep <= SEP_SPACE;
`endif
               end else begin
                  r_grp_cnt <= r_grp_cnt + 4'd1;
               end
            end else begin
               r_sep <= (r_sep == SEP_CR) ? SEP_LF : SEP_NONE;
            end
         end
      end
   end

endmodule
